// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_pkg;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

    localparam int RF_INIT_ZERO  = 0;
    localparam int RF_INIT_INDEX = 1;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset fill sequencer: walks every writable register once, then
// enters RUN and raises ready until the next reset.
module rf_init_seq
    import rf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic [DATA_W-1:0] init_data_o,
    output logic              run_o,
    output logic              ready_o
);

    // Register 0 is skipped when it is hard-wired to zero.
    localparam logic [ADDR_W-1:0] CNT_START = (ZERO_REG != 0) ? ADDR_W'(1) : '0;

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_INIT;
            cnt_q   <= CNT_START;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        init_we_o = 1'b0;
        case (state_q)
            RF_INIT: begin
                init_we_o = 1'b1;
                if (&cnt_q) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_RUN:  ;
            default: state_d = RF_INIT;
        endcase
    end

    assign init_addr_o = cnt_q;
    assign init_data_o = (INIT_MODE == RF_INIT_INDEX) ? DATA_W'(cnt_q) : '0;
    assign run_o       = (state_q == RF_RUN);
    assign ready_o     = ready_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: combinational reads with optional forwarding,
// prioritised multi-port writes, and a fill sequence after every reset.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     ready,
    output logic                     wr_conflict,
    output logic                     init_drop
);

    localparam int DEPTH = rf_depth(ADDR_W);

    if (DATA_W < ADDR_W) begin : g_width_check
        $error("register_file_mp: DATA_W must be >= ADDR_W");
    end

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              run;

    rf_init_seq #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .INIT_MODE(INIT_MODE)
    ) u_init_seq (
        .clk_i      (clk),
        .rst_ni     (rst),
        .init_we_o  (init_we),
        .init_addr_o(init_addr),
        .init_data_o(init_data),
        .run_o      (run),
        .ready_o    (ready)
    );

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wa  [NUM_WR];
    logic [DATA_W-1:0] wd  [NUM_WR];
    logic [NUM_WR-1:0] acc;

    // A write is accepted only in RUN and never to a hard-wired zero register.
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign wa[p]  = wr_addr[p*ADDR_W +: ADDR_W];
        assign wd[p]  = wr_data[p*DATA_W +: DATA_W];
        assign acc[p] = wr_en[p] && run && !((ZERO_REG != 0) && (wa[p] == '0));
    end

    // Ascending port order makes the highest-index port win a collision.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (acc[p]) begin
                mem_q[wa[p]] <= wd[p];
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        assign ra = rd_addr[r*ADDR_W +: ADDR_W];
        always_comb begin
            rv = mem_q[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (acc[p] && (wa[p] == ra)) begin
                        rv = wd[p];
                    end
                end
            end
            if (!run || ((ZERO_REG != 0) && (ra == '0))) begin
                rv = '0;
            end
        end
        assign rd_data[r*DATA_W +: DATA_W] = rv;
    end

    logic wr_conflict_q, wr_conflict_d;
    logic init_drop_q, init_drop_d;

    always_comb begin
        wr_conflict_d = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (acc[p] && acc[q] && (wa[p] == wa[q])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    assign init_drop_d = !run && (|wr_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_conflict_q <= 1'b0;
            init_drop_q   <= 1'b0;
        end else begin
            wr_conflict_q <= wr_conflict_d;
            init_drop_q   <= init_drop_d;
        end
    end

    assign wr_conflict = wr_conflict_q;
    assign init_drop   = init_drop_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: default build, a no-zero/no-bypass
// build sharing its inputs, and a narrow 4-read/1-write build.
`timescale 1ns/1ps
module tb_register_file_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus for u0 (defaults) and u1 (ZERO_REG=0, BYPASS=0)
    logic [14:0]  ra;
    logic [1:0]   we;
    logic [9:0]   wa;
    logic [63:0]  wd;
    logic [95:0]  rd0, rd1;
    logic         ready0, conf0, drop0;
    logic         ready1, conf1, drop1;

    // u2: NUM_RD=4, NUM_WR=1, ADDR_W=3, INIT_MODE=0
    logic [11:0]  ra2;
    logic [0:0]   we2;
    logic [2:0]   wa2;
    logic [31:0]  wd2;
    logic [127:0] rd2;
    logic         ready2, conf2, drop2;

    register_file_mp u0 (
        .clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd0), .wr_en(we),
        .wr_addr(wa), .wr_data(wd), .ready(ready0), .wr_conflict(conf0),
        .init_drop(drop0)
    );

    register_file_mp #(.ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd1), .wr_en(we),
        .wr_addr(wa), .wr_data(wd), .ready(ready1), .wr_conflict(conf1),
        .init_drop(drop1)
    );

    register_file_mp #(.NUM_RD(4), .NUM_WR(1), .ADDR_W(3), .INIT_MODE(0)) u2 (
        .clk(clk), .rst(rst), .rd_addr(ra2), .rd_data(rd2), .wr_en(we2),
        .wr_addr(wa2), .wr_data(wd2), .ready(ready2), .wr_conflict(conf2),
        .init_drop(drop2)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [31:0] m2 [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] w32(input logic [127:0] v, input int p);
        return v[p*32 +: 32];
    endfunction

    task automatic init_models();
        for (int i = 0; i < 32; i++) begin
            m0[i] = 32'(i);
            m1[i] = 32'(i);
        end
        for (int i = 0; i < 8; i++) m2[i] = 32'h0;
    endtask

    // Expected read for u0: reg 0 is zero; otherwise the highest enabled port
    // writing this address (same cycle) beats the stored value.
    function automatic logic [31:0] exp_u0(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we[1] && wa[9:5] == a) return wd[63:32];
        if (we[0] && wa[4:0] == a) return wd[31:0];
        return m0[a];
    endfunction

    function automatic logic [31:0] exp_u2(input logic [2:0] a);
        if (a == 3'd0) return 32'h0;
        if (we2[0] && wa2 == a) return wd2;
        return m2[a];
    endfunction

    function automatic logic exp_conf0();
        return (we == 2'b11) && (wa[4:0] == wa[9:5]) && (wa[4:0] != 5'd0);
    endfunction

    function automatic logic exp_conf1();
        return (we == 2'b11) && (wa[4:0] == wa[9:5]);
    endfunction

    task automatic commit_models();
        if (we[0] && wa[4:0] != 5'd0) m0[wa[4:0]] = wd[31:0];
        if (we[1] && wa[9:5] != 5'd0) m0[wa[9:5]] = wd[63:32];
        if (we[0]) m1[wa[4:0]] = wd[31:0];
        if (we[1]) m1[wa[9:5]] = wd[63:32];
        if (we2[0] && wa2 != 3'd0) m2[wa2] = wd2;
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  rda;
        logic [31:0] now0, now1, nxt0, nxt1;
        logic        c0, c1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5,
                   32'hDEADBEEF, 32'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 5'd9,
                   32'h22, 32'd9, 32'h22, 32'h22, 1'b1, 1'b1};
        tbl[2] = '{2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0, 5'd0,
                   32'h0, 32'h0, 32'h0, 32'hFFFF, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd0,
                   32'h0, 32'hFFFF, 32'h0, 32'h5678, 1'b0, 1'b1};
        tbl[4] = '{2'b11, 5'd3, 32'hA, 5'd4, 32'hB, 5'd3,
                   32'hA, 32'd3, 32'hA, 32'hA, 1'b0, 1'b0};
        tbl[5] = '{2'b10, 5'd0, 32'h0, 5'd31, 32'h80000000, 5'd31,
                   32'h80000000, 32'd31, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
        tbl[6] = '{2'b00, 5'd6, 32'h77, 5'd0, 32'h0, 5'd6,
                   32'd6, 32'd6, 32'd6, 32'd6, 1'b0, 1'b0};

        rst = 1'b0; ra = '0; we = '0; wa = '0; wd = '0;
        ra2 = '0; we2 = '0; wa2 = '0; wd2 = '0;
        ra[4:0] = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd0);
        chk("rst_ready2", 32'(ready2), 32'd0);
        chk("rst_conf0",  32'(conf0),  32'd0);
        chk("rst_drop0",  32'(drop0),  32'd0);
        chk("rst_rd0",    w32(rd0, 0), 32'd0);

        // Release reset and count init edges; a write arrives before edge 10
        rst = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            if (e == 10) begin
                we = 2'b01; wa[4:0] = 5'd12; wd[31:0] = 32'hAAAA;
            end
            @(posedge clk);
            #1;
            if (e == 10) begin
                chk("init_drop0_pulse", 32'(drop0), 32'd1);
                chk("init_drop1_pulse", 32'(drop1), 32'd1);
                we = 2'b00;
            end
            if (e == 11) chk("init_drop0_clear", 32'(drop0), 32'd0);
            if (e < 31) begin
                chk($sformatf("init_ready0_e%0d", e), 32'(ready0), 32'd0);
                chk($sformatf("init_rd0_e%0d", e), w32(rd0, 0), 32'd0);
            end
            if (e == 31) begin
                chk("ready0_e31", 32'(ready0), 32'd1);
                chk("rd0_reg7",   w32(rd0, 0), 32'd7);
                chk("ready1_e31", 32'(ready1), 32'd0);
            end
            if (e == 32) chk("ready1_e32", 32'(ready1), 32'd1);
            if (e == 6)  chk("ready2_e6",  32'(ready2), 32'd0);
            if (e == 7)  chk("ready2_e7",  32'(ready2), 32'd1);
        end

        init_models();
        ra[4:0] = 5'd12; #1;
        chk("drop_target0", w32(rd0, 0), 32'd12);
        chk("drop_target1", w32(rd1, 0), 32'd12);
        ra[4:0] = 5'd31; #1;
        chk("reg31_u0", w32(rd0, 0), 32'd31);
        ra[4:0] = 5'd0; #1;
        chk("reg0_u1_init", w32(rd1, 0), 32'd0);
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) ra2[p*3 +: 3] = 3'(r*4 + p);
            #1;
            for (int p = 0; p < 4; p++)
                chk($sformatf("u2_init_reg%0d", r*4 + p), w32(rd2, p), 32'd0);
        end

        // Directed vectors: same-cycle read, post-edge read, conflict flag
        for (int i = 0; i < 7; i++) begin
            we = tbl[i].en; wa = {tbl[i].a1, tbl[i].a0}; wd = {tbl[i].d1, tbl[i].d0};
            ra[9:5] = tbl[i].rda;
            #1;
            chk($sformatf("vec%0d_now_u0", i), w32(rd0, 1), tbl[i].now0);
            chk($sformatf("vec%0d_now_u1", i), w32(rd1, 1), tbl[i].now1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_conf_u0", i), 32'(conf0), 32'(tbl[i].c0));
            chk($sformatf("vec%0d_conf_u1", i), 32'(conf1), 32'(tbl[i].c1));
            commit_models();
            we = 2'b00;
            #1;
            chk($sformatf("vec%0d_nxt_u0", i), w32(rd0, 1), tbl[i].nxt0);
            chk($sformatf("vec%0d_nxt_u1", i), w32(rd1, 1), tbl[i].nxt1);
        end

        // Randomised traffic against the models, all three instances
        for (int it = 0; it < 300; it++) begin
            we = 2'($urandom);
            wa = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
            wd = {$urandom, $urandom};
            for (int p = 0; p < 3; p++) ra[p*5 +: 5] = 5'($urandom_range(0, 9));
            we2 = 1'($urandom); wa2 = 3'($urandom); wd2 = $urandom; ra2 = 12'($urandom);
            #1;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("rnd%0d_u0_p%0d", it, p), w32(rd0, p), exp_u0(ra[p*5 +: 5]));
                chk($sformatf("rnd%0d_u1_p%0d", it, p), w32(rd1, p), m1[ra[p*5 +: 5]]);
            end
            for (int p = 0; p < 4; p++)
                chk($sformatf("rnd%0d_u2_p%0d", it, p), w32(rd2, p), exp_u2(ra2[p*3 +: 3]));
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_conf0", it), 32'(conf0), 32'(exp_conf0()));
            chk($sformatf("rnd%0d_conf1", it), 32'(conf1), 32'(exp_conf1()));
            chk($sformatf("rnd%0d_conf2", it), 32'(conf2), 32'd0);
            chk($sformatf("rnd%0d_drop0", it), 32'(drop0), 32'd0);
            commit_models();
        end
        we = 2'b00; we2 = 1'b0;

        // Reset in the middle of RUN: ready must fall without a clock edge
        ra[4:0] = 5'd3;
        #2;
        rst = 1'b0;
        #1;
        chk("midrun_ready0_async", 32'(ready0), 32'd0);
        chk("midrun_ready2_async", 32'(ready2), 32'd0);
        chk("midrun_rd0_zero",     w32(rd0, 0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        chk("rerun_ready0", 32'(ready0), 32'd1);
        chk("rerun_ready1", 32'(ready1), 32'd1);
        init_models();
        for (int i = 0; i < 32; i++) begin
            ra[4:0] = 5'(i);
            #1;
            chk($sformatf("rerun_u0_reg%0d", i), w32(rd0, 0), m0[i]);
            chk($sformatf("rerun_u1_reg%0d", i), w32(rd1, 0), m1[i]);
        end
        for (int p = 0; p < 4; p++) ra2[p*3 +: 3] = 3'(p + 4);
        #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("rerun_u2_p%0d", p), w32(rd2, p), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
